// File: rtl/round_permutation_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// round_permutation_pipe : per-lane constant rotate (left=encrypt, right=decrypt)
// feeding a 2-entry valid/ready output buffer.   Rev 1.0
// ----------------------------------------------------------------------------
module round_permutation_pipe #(
  parameter int                     LANE_W   = 16,
  parameter int                     LANES    = 4,
  parameter int                     ROT_W    = $clog2(LANE_W),
  parameter logic [LANES*ROT_W-1:0] ROT_AMTS = 16'h9741
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_dir,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data
);

  localparam int DW = LANES * LANE_W;

  logic [DW-1:0] perm;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int R = int'(ROT_AMTS[i*ROT_W +: ROT_W]);
    logic [LANE_W-1:0] lane;
    assign lane = in_data[i*LANE_W +: LANE_W];

    if (R == 0) begin : g_pass
      assign perm[i*LANE_W +: LANE_W] = lane;
    end else begin : g_rot
      logic [LANE_W-1:0] rol;
      logic [LANE_W-1:0] ror;
      assign rol = {lane[LANE_W-1-R:0], lane[LANE_W-1:LANE_W-R]};
      assign ror = {lane[R-1:0], lane[LANE_W-1:R]};
      assign perm[i*LANE_W +: LANE_W] = in_dir ? ror : rol;
    end
  end

  logic [1:0]    count_q, count_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          accept;
  logic          pop;

  // Ready depends only on occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q ^ pop;
    tail_d  = tail_q ^ accept;
    mem_d   = mem_q;
    if (accept) mem_d[tail_q] = perm;
    if (accept && !pop)      count_d = count_q + 2'd1;
    else if (!accept && pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      mem_q   <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/round_permutation_pipe.md
# round_permutation_pipe

Registered, parametrised successor to the combinational round permutation of the block cipher datapath. Splits a `LANES*LANE_W`-bit state into lanes and rotates each lane by its own compile-time amount, left for encryption or right for decryption, selected per transaction. Output goes through a 2-entry buffer with valid/ready handshakes on both sides, so the block can sit between pipelined round stages and sustain one transaction per cycle under backpressure.

## Interface
Parameters:
- `LANE_W`, default 16: lane width in bits; power of two, ≥ 2.
- `LANES`, default 4: number of lanes; ≥ 1.
- `ROT_W`, default `$clog2(LANE_W)` (4): width of one rotation field; derived, not overridden.
- `ROT_AMTS`, default `16'h9741`: packed rotation amounts, `LANES*ROT_W` bits.
  - Field `ROT_AMTS[i*ROT_W +: ROT_W]` applies to lane `i`.
  - Defaults: lane3 = 9, lane2 = 7, lane1 = 4, lane0 = 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input transaction valid.
- `in_ready`  out  1  block can accept an input this cycle.
- `in_dir`  in  1  0 = rotate left (encrypt), 1 = rotate right (decrypt).
- `in_data`  in  `LANES*LANE_W`  state in; lane `i` = `in_data[i*LANE_W +: LANE_W]`.
- `out_valid`  out  1  `out_data` holds a valid result.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  `LANES*LANE_W`  permuted state.

## Operation
- Per lane, with `r = ROT_AMTS` field `i`:
  - `in_dir=0`: `out_lane = (in_lane << r) | (in_lane >> (LANE_W-r))`.
  - `in_dir=1`: rotate right by `r`.
  - `r = 0` passes the lane unchanged. `ROT_W` bits cannot exceed `LANE_W-1`, so no modulo case exists.
- The permutation is computed combinationally from `in_data`/`in_dir` and written into the buffer. No lane crosses into another lane.
- Buffer: 2 entries, FIFO order, tracked by occupancy `count` ∈ {0,1,2}.
- Accept happens when `in_valid && in_ready`; the permuted word is written at the tail.
- Pop happens when `out_valid && out_ready`; the head advances.
- `in_ready = (count != 2)`. This is a function of registered state only; it has no combinational path from `out_ready`.
- `out_valid = (count != 0)`. `out_data` = head entry.
- Accept and pop in the same cycle: `count` is unchanged and order is preserved.
- When full, no accept occurs, even if a pop happens that cycle. `in_ready` rises on the cycle after the pop.
- `in_valid` while `in_ready=0` is ignored. The upstream holds its data, per the handshake rule.
- `out_data` holds stable while `out_valid && !out_ready`.
- `out_data` is don't-care when `out_valid=0`; the implementation drives 0 for that case.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - `count=0`, head/tail pointers 0, entries cleared to 0.
  - Next cycle: `out_valid=0`, `in_ready=1`, `out_data=0`.
- A reset mid-operation discards all buffered entries. Handshakes asserted during the reset cycle are not honoured.
- Latency: an input accepted at edge N appears on `out_data` with `out_valid=1` after edge N (valid in cycle N+1), provided the buffer was empty.
- Throughput: 1 transaction/cycle while `out_ready=1` continuously; `count` stays ≤ 1.
- With `out_ready=0`, two transactions are absorbed, then `in_ready=0`.
- Pointer wrap: 1-bit head/tail pointers toggle modulo 2.
- `in_dir` is sampled only on the accept cycle and applies to that transaction alone.

## Test plan
- Encrypt, default params:
  - Stimulus: `in_data=64'h8000_0001_0001_8000`, `in_dir=0`, `out_ready=1`.
  - Response: `64'h0100_0080_0010_0001` one cycle later, `out_valid` high for exactly 1 cycle.
- Decrypt round trip:
  - Stimulus: feed `64'h0100_0080_0010_0001` with `in_dir=1`.
  - Response: `64'h8000_0001_0001_8000`.
  - Also: 1000 random words through encrypt then decrypt; every output must equal its original input.
- Backpressure/full:
  - Stimulus: `out_ready=0`, push A=`64'h1`, then B=`64'h2` on consecutive cycles.
  - Response: `in_ready=0` after the second accept, and a third word C held on `in_data` is not taken.
  - Then raise `out_ready`: outputs are perm(A), then perm(B), then perm(C), with `in_ready` high again one cycle after the first pop.
- Streaming: 64 back-to-back inputs with `out_ready=1`.
  - Response: 64 consecutive outputs, in order, with no bubbles.
  - Also: alternating `in_dir` each beat; each output must follow its own direction.
- Reset mid-operation: buffer full, then `rst_n=0` for 1 cycle.
  - Response: `out_valid=0`, `in_ready=1`, `out_data=0` next cycle; no stale word emitted afterwards.
- Parameter variant: `LANE_W=8`, `LANES=2`, `ROT_AMTS=6'o30` (lane1=3, lane0=0).
  - Stimulus: `16'h8181` with `in_dir=0`.
  - Response: `16'h0C81`.
